// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage MIPS core: control bundle layout and opcodes.
package pipe_pkg;

    // ID-stage control bundle {regdst, alusrc, aluop[1:0], memread, memwrite, branch, regwrite, memtoreg}
    localparam int CTRL_W        = 9;
    localparam int CTRL_REGDST   = 8;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_ALUOP_HI = 6;
    localparam int CTRL_ALUOP_LO = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_MEMTOREG = 0;

    // sll $0,$0,0 -- the architectural nop, all zeros
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Opcodes shared with hazard detection and decode
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/pipe_hazard_response_sat_counter.sv
// Saturating up-counter used for stall/flush performance debug.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    // Next count: step by one while inc is high, stick at all-ones
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}}))
            count_d = count_q + W'(1);
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_response.sv
// IF/ID and ID/EX pipeline registers acting on load-use stall, bubble and branch flush.
module pipe_hazard_response #(
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              bubble_sel,
    input  logic              flush,
    input  logic [31:0]       if_instr,
    input  logic [31:0]       if_pc4,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic [31:0]       id_imm,
    output logic              pc_write,
    output logic [31:0]       ifid_instr,
    output logic [31:0]       ifid_pc4,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic              ex_memread,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import pipe_pkg::*;

    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [31:0]       ifid_pc4_q, ifid_pc4_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [31:0]       ex_rs_data_q, ex_rt_data_q, ex_imm_q;
    logic [4:0]        ex_rs_q, ex_rt_q, ex_rd_q;

    // PC holds on stall; held enabled while in reset so fetch restarts cleanly
    assign pc_write = ~stall | ~rst_n;

    // IF/ID next state: flush beats stall beats normal load
    always_comb begin
        ifid_instr_d = if_instr;
        ifid_pc4_d   = if_pc4;
        if (flush) begin
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = 32'h0;
        end else if (stall) begin
            ifid_instr_d = ifid_instr_q;
            ifid_pc4_d   = ifid_pc4_q;
        end
    end

    // ID/EX control: bubble forces every control bit low, so no X reaches EX control
    always_comb begin
        ex_ctrl_d = bubble_sel ? '0 : id_ctrl;
    end

    // IF/ID register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    // ID/EX register: loads every edge, no hold path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q    <= '0;
            ex_rs_data_q <= 32'h0;
            ex_rt_data_q <= 32'h0;
            ex_imm_q     <= 32'h0;
            ex_rs_q      <= 5'h0;
            ex_rt_q      <= 5'h0;
            ex_rd_q      <= 5'h0;
        end else begin
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rs_data_q <= id_rs_data;
            ex_rt_data_q <= id_rt_data;
            ex_imm_q     <= id_imm;
            ex_rs_q      <= ifid_instr_q[25:21];
            ex_rt_q      <= ifid_instr_q[20:16];
            ex_rd_q      <= ifid_instr_q[15:11];
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .count (flush_cnt)
    );

    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_rs_data = ex_rs_data_q;
    assign ex_rt_data = ex_rt_data_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rs      = ex_rs_q;
    assign ex_rt      = ex_rt_q;
    assign ex_rd      = ex_rd_q;
    // Loaded instruction's memread, fed back to hazard detection
    assign ex_memread = ex_ctrl_q[CTRL_MEMREAD];

endmodule

// File: tb/tb_pipe_hazard_response.sv
// Directed, table-driven bench for pipe_hazard_response (CNT_W = 4 to reach saturation).
module tb_pipe_hazard_response;

    localparam int CW = 9;
    localparam int NW = 4;

    logic          clk, rst_n;
    logic          stall, bubble_sel, flush;
    logic [31:0]   if_instr, if_pc4, id_rs_data, id_rt_data, id_imm;
    logic [CW-1:0] id_ctrl;
    logic          pc_write, ex_memread;
    logic [31:0]   ifid_instr, ifid_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [CW-1:0] ex_ctrl;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [NW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_response #(.CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .bubble_sel(bubble_sel), .flush(flush),
        .if_instr(if_instr), .if_pc4(if_pc4), .id_ctrl(id_ctrl),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .pc_write(pc_write), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
        .ex_ctrl(ex_ctrl), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, bub, flush;
        logic [31:0] instr, pc4;
        logic [8:0]  ctrl;
        logic        e_pcw;
        logic [31:0] e_instr, e_pc4;
        logic [8:0]  e_ctrl;
        logic [4:0]  e_rs, e_rt, e_rd;
        logic        e_mr;
        logic [3:0]  e_sc, e_fc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic s, input logic b, input logic f,
        input logic [31:0] ins, input logic [31:0] p, input logic [8:0] c,
        input logic pcw, input logic [31:0] ei, input logic [31:0] ep, input logic [8:0] ec,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic mr, input logic [3:0] sc, input logic [3:0] fc);
        vec_t v;
        v.stall = s; v.bub = b; v.flush = f; v.instr = ins; v.pc4 = p; v.ctrl = c;
        v.e_pcw = pcw; v.e_instr = ei; v.e_pc4 = ep; v.e_ctrl = ec;
        v.e_rs = rs; v.e_rt = rt; v.e_rd = rd; v.e_mr = mr; v.e_sc = sc; v.e_fc = fc;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, " ifid_instr"}, ifid_instr, 32'h0);
        chk({tag, " ifid_pc4"},   ifid_pc4,   32'h0);
        chk({tag, " ex_ctrl"},    32'(ex_ctrl), 32'h0);
        chk({tag, " ex_data"},    ex_rs_data | ex_rt_data | ex_imm, 32'h0);
        chk({tag, " ex_addr"},    {17'h0, ex_rs, ex_rt, ex_rd}, 32'h0);
        chk({tag, " ex_memread"}, 32'(ex_memread), 32'h0);
        chk({tag, " stall_cnt"},  32'(stall_cnt), 32'h0);
        chk({tag, " flush_cnt"},  32'(flush_cnt), 32'h0);
        chk({tag, " pc_write"},   32'(pc_write), 32'h1);
    endtask

    localparam logic [8:0]  C_ADD = 9'h142; // regdst, aluop=10, regwrite
    localparam logic [8:0]  C_LW  = 9'h093; // alusrc, memread, regwrite, memtoreg
    localparam logic [31:0] I_ADD = 32'h012A4020; // add $8,$9,$10
    localparam logic [31:0] I_LW  = 32'h8C220000; // lw $2,0($1)
    localparam logic [31:0] I_USE = 32'h00441820; // add $3,$2,$4
    localparam logic [31:0] I_X   = 32'h01234567; // rs=9 rt=3 rd=8

    initial begin
        logic [31:0] d;
        // s b f  instr         pc4     ctrl   | pcw ifid_instr ifid_pc4 ex_ctrl rs rt rd mr sc fc
        vecs[0] = mk(0,0,0, I_ADD,        32'h04, C_ADD, 1, I_ADD, 32'h04, C_ADD, 0, 0, 0, 0, 0, 0);
        vecs[1] = mk(0,0,0, I_LW,         32'h08, C_ADD, 1, I_LW,  32'h08, C_ADD, 9,10, 8, 0, 0, 0);
        vecs[2] = mk(0,0,0, I_USE,        32'h0C, C_LW,  1, I_USE, 32'h0C, C_LW,  1, 2, 0, 1, 0, 0);
        vecs[3] = mk(1,1,0, I_X,          32'h10, C_ADD, 0, I_USE, 32'h0C, 9'h0,  2, 4, 3, 0, 1, 0);
        vecs[4] = mk(0,0,0, I_X,          32'h10, C_ADD, 1, I_X,   32'h10, C_ADD, 2, 4, 3, 0, 1, 0);
        vecs[5] = mk(0,0,1, 32'hAAAA5555, 32'h14, C_LW,  1, 32'h0, 32'h0,  C_LW,  9, 3, 8, 1, 1, 1);
        vecs[6] = mk(1,1,1, 32'h11112222, 32'h18, C_ADD, 0, 32'h0, 32'h0,  9'h0,  0, 0, 0, 0, 2, 2);
        vecs[7] = mk(0,1,0, I_ADD,        32'h1C, C_LW,  1, I_ADD, 32'h1C, 9'h0,  0, 0, 0, 0, 2, 2);
        vecs[8] = mk(1,0,0, I_LW,         32'h20, C_ADD, 0, I_ADD, 32'h1C, C_ADD, 9,10, 8, 0, 3, 2);

        rst_n = 1'b0; stall = 1'b0; bubble_sel = 1'b0; flush = 1'b0;
        if_instr = 32'h0; if_pc4 = 32'h0; id_ctrl = '0;
        id_rs_data = 32'h0; id_rt_data = 32'h0; id_imm = 32'h0;
        #12;
        check_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Table: drive, check combinational pc_write, clock, check registered outputs
        for (int i = 0; i < 9; i++) begin
            d = 32'hC0DE0000 | 32'(i);
            stall = vecs[i].stall; bubble_sel = vecs[i].bub; flush = vecs[i].flush;
            if_instr = vecs[i].instr; if_pc4 = vecs[i].pc4; id_ctrl = vecs[i].ctrl;
            id_rs_data = d; id_rt_data = ~d; id_imm = d ^ 32'h00005A5A;
            #1;
            chk($sformatf("v%0d pc_write", i), 32'(pc_write), 32'(vecs[i].e_pcw));
            @(posedge clk); #1;
            chk($sformatf("v%0d ifid_instr", i), ifid_instr, vecs[i].e_instr);
            chk($sformatf("v%0d ifid_pc4", i),   ifid_pc4,   vecs[i].e_pc4);
            chk($sformatf("v%0d ex_ctrl", i),    32'(ex_ctrl), 32'(vecs[i].e_ctrl));
            chk($sformatf("v%0d ex_rs", i),      32'(ex_rs), 32'(vecs[i].e_rs));
            chk($sformatf("v%0d ex_rt", i),      32'(ex_rt), 32'(vecs[i].e_rt));
            chk($sformatf("v%0d ex_rd", i),      32'(ex_rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d ex_memread", i), 32'(ex_memread), 32'(vecs[i].e_mr));
            chk($sformatf("v%0d ex_rs_data", i), ex_rs_data, d);
            chk($sformatf("v%0d ex_rt_data", i), ex_rt_data, ~d);
            chk($sformatf("v%0d ex_imm", i),     ex_imm, d ^ 32'h00005A5A);
            chk($sformatf("v%0d stall_cnt", i),  32'(stall_cnt), 32'(vecs[i].e_sc));
            chk($sformatf("v%0d flush_cnt", i),  32'(flush_cnt), 32'(vecs[i].e_fc));
        end

        // Reset asserted mid-cycle while stalling: everything clears without a clock edge
        stall = 1'b1; bubble_sel = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset stall_cnt", 32'(stall_cnt), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");

        // First edge after release is an ordinary load
        stall = 1'b0;
        if_instr = I_ADD; if_pc4 = 32'h24; id_ctrl = C_LW;
        id_rs_data = 32'h11; id_rt_data = 32'h22; id_imm = 32'h33;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst ifid_instr", ifid_instr, I_ADD);
        chk("post-rst ifid_pc4",   ifid_pc4, 32'h24);
        chk("post-rst ex_ctrl",    32'(ex_ctrl), 32'(C_LW));
        chk("post-rst ex_memread", 32'(ex_memread), 32'h1);
        chk("post-rst stall_cnt",  32'(stall_cnt), 32'h0);

        // Saturation: 20 stalled edges, 4-bit counter must stop at 15
        stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            chk($sformatf("sat%0d stall_cnt", i), 32'(stall_cnt), (i < 15) ? 32'(i) : 32'd15);
            chk($sformatf("sat%0d ifid_hold", i), ifid_instr, I_ADD);
        end
        chk("sat flush_cnt", 32'(flush_cnt), 32'h0);
        stall = 1'b0;
        #1;
        chk("sat pc_write", 32'(pc_write), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
